gray_counter: RTL and testbench

Registered binary counter that feeds the team's binary-to-Gray conversion stage and presents each new count as a Gray-coded word on a valid/ready output. It is the upstream source for any consumer that needs single-bit-change sequences, such as pointer exchange, encoder emulation or LED pattern drivers. Binary and Gray outputs are register-aligned. Counting stalls under output back-pressure, and a one-cycle pulse marks every wrap.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_encode.sv | 13 +
 rtl/gray_counter.sv | 91 +++++++++
 tb/tb_gray_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, FSM state type, reference conversion.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;

    // IDLE: nothing presented downstream. PEND: bin_q/gray_q hold an unconsumed value.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } gray_cnt_state_t;

    function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray converter, WIDTH bits. Ports: bin_i (binary in), gray_o (Gray out).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; no handshake on this path.
module gray_encode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered binary counter with register-aligned Gray output on a valid/ready port, plus a wrap pulse.
// Latency: 1 cycle from en/load/clr to bin_q/gray_q/out_valid/wrap; all outputs registered.
// Backpressure: out_ready=0 while a value is pending freezes the count and drops en (no queuing).
// Ports: clk, rst (async active-high), en, clr, load, load_val, [dir], bin_q, gray_q,
//        out_valid, out_ready, wrap.
// Build option: define GRAY_CNT_DOWN_EN to add the dir port and down counting (dir=1).
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef GRAY_CNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap
);

    gray_cnt_state_t state_q, state_d;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q, wrap_d;
    logic             advance;

    // A pending value blocks counting unless the consumer takes it this same edge.
    assign advance = en && ((state_q == IDLE) || out_ready);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        wrap_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            bin_d   = '0;
        end else if (load) begin
            state_d = PEND;
            bin_d   = load_val;
        end else if (advance) begin
            state_d = PEND;
`ifdef GRAY_CNT_DOWN_EN
            if (dir) begin
                bin_d  = bin_q - 1'b1;
                wrap_d = (bin_q == '0);
            end else begin
                bin_d  = bin_q + 1'b1;
                wrap_d = &bin_q;
            end
`else
            bin_d  = bin_q + 1'b1;
            wrap_d = &bin_q;
`endif
        end else if ((state_q == PEND) && out_ready) begin
            state_d = IDLE;
        end
    end

    // Encode the next binary value so gray_q lands on the same edge as bin_q.
    gray_encode #(
        .WIDTH (WIDTH)
    ) u_gray_encode (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out_valid = (state_q == PEND);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed vector table, corner sequences, randomized model check.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: exercised through out_ready in both directed and random phases.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, load, out_ready;
    logic [3:0] load_val;
`ifdef GRAY_CNT_DOWN_EN
    logic       dir;
`endif
    logic [3:0] bin_q, gray_q;
    logic       out_valid, wrap;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
`ifdef GRAY_CNT_DOWN_EN
        .dir       (dir),
`endif
        .bin_q     (bin_q),
        .gray_q    (gray_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap)
    );

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       rdy;
        logic [3:0] eb;
        logic [3:0] eg;
        logic       ev;
        logic       ew;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int eb, input int eg, input int ev, input int ew);
        chk({tag, ".bin"},   int'(bin_q),     eb);
        chk({tag, ".gray"},  int'(gray_q),    eg);
        chk({tag, ".valid"}, int'(out_valid), ev);
        chk({tag, ".wrap"},  int'(wrap),      ew);
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] lv, input logic e, input logic r);
        clr = c; load = l; load_val = lv; en = e; out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: count as plain integer plus a "something pending" flag.
    int  m_cnt;
    bit  m_pend;
    bit  m_wrap;
    bit  m_adv;

    function automatic int gray_of(input int v);
        return v ^ (v / 2);
    endfunction

    initial begin
        // clr ld  lv  en rdy  bin gray v  w
        tbl[0]  = '{0, 0, 4'd0,  1, 1, 4'd1,  4'b0001, 1, 0};
        tbl[1]  = '{0, 0, 4'd0,  1, 1, 4'd2,  4'b0011, 1, 0};
        tbl[2]  = '{0, 0, 4'd0,  1, 1, 4'd3,  4'b0010, 1, 0};
        tbl[3]  = '{0, 0, 4'd0,  1, 1, 4'd4,  4'b0110, 1, 0};
        tbl[4]  = '{0, 1, 4'd15, 0, 1, 4'd15, 4'b1000, 1, 0};
        tbl[5]  = '{0, 0, 4'd0,  1, 1, 4'd0,  4'b0000, 1, 1};
        tbl[6]  = '{0, 0, 4'd0,  1, 1, 4'd1,  4'b0001, 1, 0};
        tbl[7]  = '{0, 0, 4'd0,  1, 0, 4'd1,  4'b0001, 1, 0};
        tbl[8]  = '{0, 0, 4'd0,  1, 0, 4'd1,  4'b0001, 1, 0};
        tbl[9]  = '{0, 0, 4'd0,  1, 0, 4'd1,  4'b0001, 1, 0};
        tbl[10] = '{0, 0, 4'd0,  1, 1, 4'd2,  4'b0011, 1, 0};
        tbl[11] = '{1, 1, 4'd9,  1, 1, 4'd0,  4'b0000, 0, 0};
        tbl[12] = '{0, 1, 4'd9,  0, 0, 4'd9,  4'b1101, 1, 0};
        tbl[13] = '{0, 0, 4'd0,  0, 1, 4'd9,  4'b1101, 0, 0};
        tbl[14] = '{0, 0, 4'd0,  0, 0, 4'd9,  4'b1101, 0, 0};
        tbl[15] = '{0, 0, 4'd0,  1, 0, 4'd10, 4'b1111, 1, 0};
        tbl[16] = '{0, 0, 4'd0,  0, 0, 4'd10, 4'b1111, 1, 0};
        tbl[17] = '{0, 1, 4'd14, 0, 0, 4'd14, 4'b1001, 1, 0};

        rst = 1'b1;
        drive(0, 0, 4'd0, 0, 0);
`ifdef GRAY_CNT_DOWN_EN
        dir = 1'b0;
`endif
        #12;
        rst = 1'b0;
        #1;
        chk_all("reset", 0, 0, 0, 0);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].rdy);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].eb, tbl[i].eg, tbl[i].ev, tbl[i].ew);
        end

        // Count to 6, stall, then async reset between edges.
        drive(1, 0, 4'd0, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 4'd0, 1, 1);
            step();
        end
        chk("pre_rst.bin", int'(bin_q), 6);
        drive(0, 0, 4'd0, 1, 0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        step();
        chk_all("rst_held", 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        drive(0, 0, 4'd0, 1, 1);
        step();
        chk_all("post_rst", 1, 1, 1, 0);

`ifdef GRAY_CNT_DOWN_EN
        rst = 1'b1;
        #2;
        rst = 1'b0;
        dir = 1'b1;
        drive(0, 0, 4'd0, 1, 1);
        step();
        chk_all("down_wrap", 15, 4'b1000, 1, 1);
        step();
        chk_all("down_step", 14, 4'b1001, 1, 0);
        dir = 1'b0;
`endif

        // Randomized phase against the behavioural model.
        drive(1, 0, 4'd0, 0, 0);
        step();
        m_cnt  = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic c, l, e, r;
            logic [3:0] lv;
            bit down;
            logic [3:0] prev_gray;
            c  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 9) == 0);
            lv = 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            down = 1'b0;
`ifdef GRAY_CNT_DOWN_EN
            down = ($urandom_range(0, 1) == 1);
            dir  = down;
`endif
            prev_gray = gray_q;
            drive(c, l, lv, e, r);

            m_wrap = 1'b0;
            m_adv  = 1'b0;
            if (c) begin
                m_cnt  = 0;
                m_pend = 1'b0;
            end else if (l) begin
                m_cnt  = int'(lv);
                m_pend = 1'b1;
            end else if (e && (!m_pend || r)) begin
                m_adv  = 1'b1;
                m_wrap = down ? (m_cnt == 0) : (m_cnt == 15);
                m_cnt  = down ? (m_cnt + 15) % 16 : (m_cnt + 1) % 16;
                m_pend = 1'b1;
            end else if (m_pend && r) begin
                m_pend = 1'b0;
            end

            step();
            chk_all($sformatf("rnd%0d", i), m_cnt, gray_of(m_cnt), int'(m_pend), int'(m_wrap));
            if (m_adv)
                chk($sformatf("rnd%0d.onebit", i), $countones(gray_q ^ prev_gray), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
